axi_wr_subordinate: RTL and testbench
=====================================

Name: axi_wr_subordinate

Overview:
AXI4 write-channel subordinate, acting as the responder end of the manager AW/W/B interface the CPU exposes. It accepts one write burst at a time (AW, then W beats, then B) and turns each accepted data beat into a registered word write on a simple single-port SRAM interface. It sits between the CPU's AXI manager port and the data memory. The read channels are handled by a separate block.

Parameters:
ID_W, 1, width of AWID/BID
MEM_BASE, 32'h0000_0000, byte address of the first memory word
MEM_BYTES, 4096, memory size in bytes; power of two, at least 4

Ports:
ACLK  in  1  global clock
RESETn  in  1  synchronous reset, active low
S_AXI_AWID  in  ID_W  write address ID
S_AXI_AWADDR  in  32  burst start byte address
S_AXI_AWLEN  in  8  beats minus 1
S_AXI_AWSIZE  in  3  log2 bytes per beat
S_AXI_AWBURST  in  2  0=FIXED, 1=INCR, 2=WRAP
S_AXI_AWVALID  in  1  address valid
S_AXI_AWREADY  out  1  address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WLAST  in  1  last beat flag
S_AXI_WVALID  in  1  data valid
S_AXI_WREADY  out  1  data ready
S_AXI_BID  out  ID_W  response ID (the latched AWID)
S_AXI_BRESP  out  2  0=OKAY, 2=SLVERR
S_AXI_BVALID  out  1  response valid
S_AXI_BREADY  in  1  response ready
mem_addr  out  log2(MEM_BYTES)-2  word index
mem_wdata  out  32  write data
mem_be  out  4  byte enables
mem_we  out  1  write enable, one-cycle pulse

Behaviour:
- Clock and reset: single clock ACLK. RESETn is synchronous and active low, sampled on the rising edge of ACLK.
- Reset: state IDLE. AWREADY, WREADY, BVALID, mem_we and beat counter are 0. BRESP, BID, mem_addr, mem_wdata and mem_be are 0.
  - AWREADY rises in the first cycle after RESETn is released.
- Reset mid-burst: aborts the burst immediately. No B response is ever issued for the aborted burst, and no further mem_we pulses occur.
- State IDLE:
  - AWREADY=1, WREADY=0.
  - On AWVALID&&AWREADY: latch ID, address, len, size and burst into registers. Clear the error flag and beat counter. Next state DATA; AWREADY drops the same edge.
- Error flag is set at AW acceptance if either of these holds:
  - AWSIZE>2
  - AWBURST is WRAP or reserved (3)
- State DATA:
  - WREADY=1. Beats may arrive with WVALID gaps; each handshake is one beat.
  - Per beat: the beat is in range if (cur_addr - MEM_BASE) < MEM_BYTES, computed as an unsigned 32-bit subtraction so addresses below MEM_BASE wrap and fall out of range.
  - If the beat is in range and the error flag is clear: on the next edge mem_we=1, mem_addr=(cur_addr-MEM_BASE)>>2, mem_wdata=WDATA, mem_be=WSTRB. Strobes pass through unmodified; lane placement is the manager's job.
  - If the beat is out of range: the write is suppressed and the error flag is set.
  - mem_we is 0 on every cycle with no beat handshake.
- Address update after each beat:
  - INCR: cur_addr += (1<<size), 32-bit wrap, no 4KB check.
  - FIXED: cur_addr unchanged.
- Beat count: the counter is authoritative. The burst ends on the beat where count==len.
  - WLAST on an earlier beat sets the error flag; that beat is still written if otherwise legal.
  - WLAST missing on the final beat sets the error flag.
- End of burst: the final beat handshake moves to RESP. WREADY drops the same edge.
  - AWLEN=255 gives 256 beats; the counter is 8 bits and compares before incrementing.
- State RESP:
  - BVALID=1, BID=latched ID, BRESP = error ? 2'b10 : 2'b00.
  - BRESP and BID stay stable while BVALID is high.
  - Stay in RESP until BREADY. On BVALID&&BREADY: BVALID drops, next state IDLE, AWREADY=1 the next cycle.
  - BREADY already high on the BVALID cycle completes in 1 cycle.
- Latency: AW handshake to WREADY is 1 cycle. Beat handshake to mem_we is 1 cycle. Last beat to BVALID is 1 cycle.
- Ordering:
  - AW is never accepted while a burst is in DATA or RESP.
  - W beats presented before the AW handshake are not accepted (WREADY=0).
  - The final mem_we pulse occurs on the same cycle BVALID rises.

Decomposition:
- Package axi_pkg:
  - burst_t enum (FIXED/INCR/WRAP)
  - resp_t enum (OKAY/EXOKAY/SLVERR/DECERR)
  - wr_state_t enum (IDLE/DATA/RESP)
  - AXI_DATA_W=32, AXI_ADDR_W=32 constants
- Sub-module axi_burst_addr (combinational):
  - inputs: cur_addr, size, burst
  - output: next_addr
  - reused by the future read subordinate.

Test Plan:
1. Single beat: AW addr=0x10 len=0 size=2 INCR, W data=0xDEADBEEF strb=0xF last=1, BREADY=1 -> one mem_we with mem_addr=4, data 0xDEADBEEF, be 0xF; BVALID next cycle with BRESP=0, BID=AWID.
2. INCR 4 beats with WVALID gaps: addr=0x100, len=3, WVALID low 2 cycles between beats -> mem_addr 0x40,0x41,0x42,0x43 in order; exactly 4 mem_we pulses; BRESP=OKAY.
3. FIXED 3 beats at 0x20 with strb 0x1,0x2,0xC -> three writes all at mem_addr=8 with be 1,2,C.
4. BREADY held low 5 cycles -> BVALID, BID and BRESP stable for all 5; AWVALID asserted meanwhile is not accepted until the cycle after the B handshake.
5. Errors, one run each:
   - INCR from MEM_BASE+MEM_BYTES-4, len=1 -> 1 write then 1 suppressed, BRESP=2.
   - AWSIZE=3 -> no writes, BRESP=2.
   - WLAST early on beat 0 of len=1 -> BRESP=2.
6. RESETn low during beat 2 of a 4-beat burst -> no further mem_we, no BVALID; AWREADY=1 one cycle after release; a fresh single-beat burst completes OKAY.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI types and widths for the write (and future read) subordinate blocks.
package axi_pkg;

    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_state_t;

    // Word-index width for a memory of the given byte size; never narrower than one bit.
    function automatic int unsigned mem_aw(input int unsigned bytes);
        return ($clog2(bytes) > 2) ? int'($clog2(bytes)) - 2 : 1;
    endfunction

endpackage

// File: rtl/axi_wr_subordinate_if.sv
// AXI4 write-address, write-data and write-response channels between manager and subordinate.
interface axi_wr_subordinate_if
    import axi_pkg::*;
#(
    parameter int unsigned ID_W = 1
);

    logic [ID_W-1:0]       awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_W-1:0]       bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_burst_addr.sv
// Next beat address for an AXI burst; FIXED and unsupported burst types hold the address.
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [AXI_ADDR_W-1:0] cur_addr,
    input  logic [2:0]            size,
    input  burst_t                burst,
    output logic [AXI_ADDR_W-1:0] next_addr
);

    always_comb begin
        next_addr = cur_addr;
        if (burst == INCR) begin
            next_addr = cur_addr + (AXI_ADDR_W'(1) << size);
        end
    end

endmodule

// File: rtl/axi_wr_subordinate.sv
// AXI4 write subordinate: one burst at a time, each legal beat becomes a registered SRAM word write.
module axi_wr_subordinate
    import axi_pkg::*;
#(
    parameter int unsigned           ID_W      = 1,
    parameter logic [AXI_ADDR_W-1:0] MEM_BASE  = 32'h0000_0000,
    parameter int unsigned           MEM_BYTES = 4096
) (
    input  logic                         ACLK,
    input  logic                         RESETn,
    axi_wr_subordinate_if.slave          s_axi,
    output logic [mem_aw(MEM_BYTES)-1:0] mem_addr,
    output logic [AXI_DATA_W-1:0]        mem_wdata,
    output logic [AXI_STRB_W-1:0]        mem_be,
    output logic                         mem_we
);

    localparam int unsigned MEM_AW = mem_aw(MEM_BYTES);

    wr_state_t             state;
    logic [ID_W-1:0]       id_q;
    logic [AXI_ADDR_W-1:0] cur_addr;
    logic [7:0]            len_q;
    logic [7:0]            cnt;
    logic [2:0]            size_q;
    burst_t                burst_q;
    logic                  err;

    logic [AXI_ADDR_W-1:0] next_addr;
    logic [AXI_ADDR_W-1:0] offset;
    logic                  in_range;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  last_beat;
    logic                  err_nx;

    axi_burst_addr u_burst_addr (
        .cur_addr  (cur_addr),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Unsigned subtraction makes addresses below the base wrap high and fall out of range.
    assign offset    = cur_addr - MEM_BASE;
    assign in_range  = offset < AXI_ADDR_W'(MEM_BYTES);
    assign aw_hs     = s_axi.awvalid && s_axi.awready;
    assign w_hs      = s_axi.wvalid && s_axi.wready;
    assign last_beat = (cnt == len_q);
    // The beat counter decides where the burst ends; a WLAST that disagrees only flags an error.
    assign err_nx    = err || !in_range || (s_axi.wlast != last_beat);

    always_ff @(posedge ACLK) begin
        if (!RESETn) begin
            state         <= IDLE;
            id_q          <= '0;
            cur_addr      <= '0;
            len_q         <= '0;
            cnt           <= '0;
            size_q        <= '0;
            burst_q       <= FIXED;
            err           <= 1'b0;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bid     <= '0;
            s_axi.bresp   <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    s_axi.awready <= 1'b1;
                    if (aw_hs) begin
                        id_q          <= s_axi.awid;
                        cur_addr      <= s_axi.awaddr;
                        len_q         <= s_axi.awlen;
                        size_q        <= s_axi.awsize;
                        burst_q       <= burst_t'(s_axi.awburst);
                        err           <= (s_axi.awsize > 3'd2) || (s_axi.awburst[1] == 1'b1);
                        cnt           <= '0;
                        s_axi.awready <= 1'b0;
                        s_axi.wready  <= 1'b1;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        if (in_range && !err) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= MEM_AW'(offset >> 2);
                            mem_wdata <= s_axi.wdata;
                            mem_be    <= s_axi.wstrb;
                        end
                        err      <= err_nx;
                        cur_addr <= next_addr;
                        cnt      <= cnt + 8'd1;
                        if (last_beat) begin
                            s_axi.wready <= 1'b0;
                            s_axi.bvalid <= 1'b1;
                            s_axi.bid    <= id_q;
                            s_axi.bresp  <= err_nx ? SLVERR : OKAY;
                            state        <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (s_axi.bvalid && s_axi.bready) begin
                        s_axi.bvalid  <= 1'b0;
                        s_axi.awready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_subordinate.sv
// Directed plus randomized bursts against a beat-level reference model of the write subordinate.
module tb_axi_wr_subordinate;
    import axi_pkg::*;

    localparam int unsigned ID_W      = 1;
    localparam logic [31:0] MEM_BASE  = 32'h0000_0000;
    localparam int unsigned MEM_BYTES = 4096;
    localparam int unsigned MAW       = 10;

    typedef struct packed {
        logic [MAW-1:0] addr;
        logic [31:0]    data;
        logic [3:0]     be;
    } wr_t;

    logic           ACLK   = 1'b0;
    logic           RESETn = 1'b0;
    logic [MAW-1:0] mem_addr;
    logic [31:0]    mem_wdata;
    logic [3:0]     mem_be;
    logic           mem_we;

    axi_wr_subordinate_if #(.ID_W(ID_W)) s_axi ();

    axi_wr_subordinate #(
        .ID_W      (ID_W),
        .MEM_BASE  (MEM_BASE),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .ACLK      (ACLK),
        .RESETn    (RESETn),
        .s_axi     (s_axi),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_we    (mem_we)
    );

    always #5 ACLK = ~ACLK;

    int          n_cmp = 0;
    int          n_err = 0;
    int          bv_seen = 0;
    wr_t         wr_q[$];
    wr_t         exp_q[$];
    logic [31:0] data_a[256];
    logic [3:0]  strb_a[256];
    logic        wlast_a[256];

    always @(negedge ACLK) begin
        if (mem_we) wr_q.push_back(wr_t'{mem_addr, mem_wdata, mem_be});
        if (s_axi.bvalid) bv_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected writes and response derived beat by beat from the burst rules.
    function automatic logic [1:0] model(input logic [31:0] addr, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        logic [31:0] off;
        bit          e;
        a = addr;
        e = (size > 3'd2) || (burst >= 2'd2);
        exp_q.delete();
        for (int i = 0; i <= int'(len); i++) begin
            off = a - MEM_BASE;
            if (off < MEM_BYTES && !e) exp_q.push_back(wr_t'{MAW'(off >> 2), data_a[i], strb_a[i]});
            if (off >= MEM_BYTES) e = 1'b1;
            if (wlast_a[i] != (i == int'(len))) e = 1'b1;
            if (burst == 2'd1) a = a + (32'd1 << size);
        end
        return e ? 2'b10 : 2'b00;
    endfunction

    task automatic do_aw(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output bit ok);
        s_axi.awid    = id;
        s_axi.awaddr  = addr;
        s_axi.awlen   = len;
        s_axi.awsize  = size;
        s_axi.awburst = burst;
        s_axi.awvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge ACLK);
            if (s_axi.awready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge ACLK); #1;
        s_axi.awvalid = 1'b0;
        chk("aw_accept", 64'(ok), 64'(1));
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic l, output bit ok);
        s_axi.wdata  = d;
        s_axi.wstrb  = s;
        s_axi.wlast  = l;
        s_axi.wvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge ACLK);
            if (s_axi.wready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge ACLK); #1;
        s_axi.wvalid = 1'b0;
        if (!ok) chk("w_accept", 64'(ok), 64'(1));
    endtask

    // gap<0 picks random WVALID gaps; wl_mode 1 = early WLAST on beat 0, 2 = WLAST missing at end.
    task automatic run_burst(input string tag, input logic [ID_W-1:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input int gap, input int bdelay, input int wl_mode, input bit preset);
        logic [1:0]      exp_resp;
        logic [ID_W-1:0] b_id;
        logic [1:0]      b_resp;
        bit              ok;
        int              g;
        int              n;
        for (int i = 0; i <= int'(len); i++) begin
            if (!preset) begin
                data_a[i] = $urandom;
                strb_a[i] = 4'($urandom);
            end
            wlast_a[i] = (i == int'(len));
        end
        if (wl_mode == 1) wlast_a[0] = 1'b1;
        if (wl_mode == 2) wlast_a[len] = 1'b0;
        exp_resp = model(addr, len, size, burst);
        wr_q.delete();
        s_axi.bready = (bdelay == 0);
        do_aw(id, addr, len, size, burst, ok);
        if (!ok) return;
        chk({tag, "_wready_lat"}, 64'(s_axi.wready), 64'(1));
        for (int i = 0; i <= int'(len); i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                @(posedge ACLK); #1;
            end
            do_w(data_a[i], strb_a[i], wlast_a[i], ok);
            if (!ok) return;
        end
        chk({tag, "_bvalid_lat"}, 64'(s_axi.bvalid), 64'(1));
        b_id   = s_axi.bid;
        b_resp = s_axi.bresp;
        chk({tag, "_bid"}, 64'(b_id), 64'(id));
        chk({tag, "_bresp"}, 64'(b_resp), 64'(exp_resp));
        if (bdelay > 0) begin
            s_axi.awaddr  = $urandom;
            s_axi.awvalid = 1'b1;
            for (int c = 0; c < bdelay; c++) begin
                @(negedge ACLK);
                chk({tag, "_bvalid_hold"}, 64'(s_axi.bvalid), 64'(1));
                chk({tag, "_bid_hold"}, 64'(s_axi.bid), 64'(b_id));
                chk({tag, "_bresp_hold"}, 64'(s_axi.bresp), 64'(b_resp));
                chk({tag, "_no_aw_in_resp"}, 64'(s_axi.awready), 64'(0));
                @(posedge ACLK); #1;
            end
            s_axi.bready = 1'b1;
        end
        @(posedge ACLK); #1;
        s_axi.awvalid = 1'b0;
        s_axi.bready  = 1'b0;
        chk({tag, "_bvalid_drop"}, 64'(s_axi.bvalid), 64'(0));
        chk({tag, "_awready_back"}, 64'(s_axi.awready), 64'(1));
        chk({tag, "_n_writes"}, 64'(wr_q.size()), 64'(exp_q.size()));
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_wr_addr"}, 64'(wr_q[i].addr), 64'(exp_q[i].addr));
            chk({tag, "_wr_data"}, 64'(wr_q[i].data), 64'(exp_q[i].data));
            chk({tag, "_wr_be"}, 64'(wr_q[i].be), 64'(exp_q[i].be));
        end
    endtask

    initial begin
        bit          ok;
        logic [2:0]  r_size;
        logic [1:0]  r_burst;
        logic [7:0]  r_len;
        logic [31:0] r_addr;
        int          r_mode;
        s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = '0;
        s_axi.awburst = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
        s_axi.bready = 1'b0;
        RESETn = 1'b0;

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", 64'(s_axi.awready), 64'(0));
        chk("rst_wready", 64'(s_axi.wready), 64'(0));
        chk("rst_bvalid", 64'(s_axi.bvalid), 64'(0));
        chk("rst_bresp", 64'(s_axi.bresp), 64'(0));
        chk("rst_bid", 64'(s_axi.bid), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_mem_be", 64'(mem_be), 64'(0));
        RESETn = 1'b1;
        @(negedge ACLK);
        chk("rel_awready_pre", 64'(s_axi.awready), 64'(0));
        @(posedge ACLK); #1;
        chk("rel_awready", 64'(s_axi.awready), 64'(1));

        // W presented with no address phase is refused
        s_axi.wdata = 32'h1234_5678; s_axi.wstrb = 4'hF; s_axi.wlast = 1'b1; s_axi.wvalid = 1'b1;
        repeat (3) begin
            @(negedge ACLK);
            chk("w_before_aw", 64'(s_axi.wready), 64'(0));
        end
        @(posedge ACLK); #1;
        s_axi.wvalid = 1'b0;
        chk("w_before_aw_nowr", 64'(wr_q.size()), 64'(0));

        data_a[0] = 32'hDEAD_BEEF; strb_a[0] = 4'hF;
        run_burst("t1", 1'b1, 32'h10, 8'd0, 3'd2, 2'd1, 0, 0, 0, 1'b1);
        chk("t1_addr_abs", 64'(wr_q.size() > 0 ? wr_q[0].addr : 10'h3FF), 64'(4));

        run_burst("t2", 1'b0, 32'h100, 8'd3, 3'd2, 2'd1, 2, 0, 0, 1'b0);
        chk("t2_last_addr", 64'(wr_q.size() == 4 ? wr_q[3].addr : 10'h3FF), 64'(10'h43));

        data_a[0] = $urandom; data_a[1] = $urandom; data_a[2] = $urandom;
        strb_a[0] = 4'h1; strb_a[1] = 4'h2; strb_a[2] = 4'hC;
        run_burst("t3", 1'b1, 32'h20, 8'd2, 3'd2, 2'd0, -1, 1, 0, 1'b1);

        run_burst("t4", 1'b0, 32'h300, 8'd1, 3'd2, 2'd1, -1, 5, 0, 1'b0);

        run_burst("t5_oor", 1'b1, MEM_BASE + MEM_BYTES - 4, 8'd1, 3'd2, 2'd1, -1, 0, 0, 1'b0);
        run_burst("t5_size3", 1'b0, 32'h40, 8'd1, 3'd3, 2'd1, -1, 0, 0, 1'b0);
        run_burst("t5_early", 1'b1, 32'h80, 8'd1, 3'd2, 2'd1, -1, 0, 1, 1'b0);
        run_burst("t5_nolast", 1'b0, 32'h90, 8'd2, 3'd2, 2'd1, -1, 2, 2, 1'b0);
        run_burst("t5_wrap", 1'b1, 32'hA0, 8'd3, 3'd2, 2'd2, -1, 0, 0, 1'b0);
        run_burst("len256", 1'b0, 32'h0, 8'd255, 3'd2, 2'd1, 0, 0, 0, 1'b0);

        for (int k = 0; k < 14; k++) begin
            r_len   = 8'($urandom_range(0, 7));
            r_size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            r_burst = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            r_addr  = ($urandom_range(0, 3) == 0) ? MEM_BASE + MEM_BYTES - 32'($urandom_range(1, 16))
                                                  : MEM_BASE + 32'($urandom_range(0, MEM_BYTES - 1));
            r_mode  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_burst("rnd", 1'($urandom), r_addr, r_len, r_size, r_burst, -1,
                      int'($urandom_range(0, 3)), r_mode, 1'b0);
        end

        // Reset while the third beat of a four-beat burst is on the bus
        wr_q.delete();
        do_aw(1'b0, 32'h200, 8'd3, 3'd2, 2'd1, ok);
        do_w($urandom, 4'hF, 1'b0, ok);
        do_w($urandom, 4'hF, 1'b0, ok);
        s_axi.wdata = $urandom; s_axi.wstrb = 4'hF; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b1;
        RESETn = 1'b0;
        @(posedge ACLK); #1;
        chk("t6_we_rst", 64'(mem_we), 64'(0));
        chk("t6_wready_rst", 64'(s_axi.wready), 64'(0));
        s_axi.wvalid = 1'b0;
        @(posedge ACLK); #1;
        chk("t6_pre_writes", 64'(wr_q.size()), 64'(2));
        wr_q.delete();
        bv_seen = 0;
        RESETn = 1'b1;
        @(negedge ACLK);
        chk("t6_awready_pre", 64'(s_axi.awready), 64'(0));
        @(posedge ACLK); #1;
        chk("t6_awready", 64'(s_axi.awready), 64'(1));
        repeat (6) @(posedge ACLK);
        #1;
        chk("t6_no_writes", 64'(wr_q.size()), 64'(0));
        chk("t6_no_bvalid", 64'(bv_seen), 64'(0));
        run_burst("t6_fresh", 1'b1, 32'h40, 8'd0, 3'd2, 2'd1, 0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
